counter_enable_ctrl: RTL and testbench

- Control stage directly upstream of the 8-bit T-flip-flop counter.
- Turns start/stop/step/clear requests into the counter's `enable` and `clear_n` inputs.
- A programmable prescaler sets the count rate while running; single-step mode issues exactly one enable pulse.
- All outputs are registered, so they can drive the counter's flip-flops directly.

---
 rtl/counter_enable_ctrl.sv | 102 ++++++++++
 tb/tb_counter_enable_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_enable_ctrl.sv
// Control stage that sits in front of the 8-bit T-flip-flop counter.
// Start/stop/step/clear requests become a registered enable pulse and a
// registered active-low clear for the counter. A prescaler sets the enable
// rate while running; single-step mode issues exactly one enable pulse.
module counter_enable_ctrl #(
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  step,
    input  logic                  clr_req,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  enable,
    output logic                  cnt_clear_n,
    output logic                  running,
    output logic [1:0]            state
);

    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StRun  = 2'b01;
    localparam logic [1:0] StStep = 2'b10;

    logic [1:0]            state_q, state_d;
    logic [PRESCALE_W-1:0] div_q, div_d;
    logic                  enable_q, enable_d;
    logic                  clear_n_q, clear_n_d;
    logic                  running_q;

    // Next-state logic; request priority is clr_req > stop > start > step.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        enable_d  = 1'b0;
        clear_n_d = ~clr_req;

        if (clr_req) begin
            // Counter clear wins over any pending pulse, including a STEP one.
            div_d = '0;
            if (state_q == StStep) begin
                state_d = StIdle;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (stop) begin
                        state_d = StIdle;
                    end else if (start) begin
                        state_d = StRun;
                        div_d   = '0;
                    end else if (step) begin
                        state_d  = StStep;
                        enable_d = 1'b1;
                    end
                end
                StRun: begin
                    if (stop) begin
                        // A terminal count coinciding with stop is dropped.
                        state_d = StIdle;
                    end else if (div_q >= prescale) begin
                        // Live compare: lowering prescale below div fires at once,
                        // so div never has to wrap.
                        enable_d = 1'b1;
                        div_d    = '0;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                StStep: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= StIdle;
            div_q     <= '0;
            enable_q  <= 1'b0;
            clear_n_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            enable_q  <= enable_d;
            clear_n_q <= clear_n_d;
            running_q <= (state_d == StRun);
        end
    end

    assign enable      = enable_q;
    assign cnt_clear_n = clear_n_q;
    assign running     = running_q;
    assign state       = state_q;

endmodule

// File: tb/tb_counter_enable_ctrl.sv
// Scoreboard bench for counter_enable_ctrl: a cycle model predicts outputs
// each time stimulus is applied, the prediction is queued, and it is popped
// and compared one clock later. A downstream 8-bit counter is modelled from
// the DUT outputs and checked against the model and fixed scenario values.
module tb_counter_enable_ctrl;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       step = 1'b0;
    logic       clr_req = 1'b0;
    logic [7:0] prescale = 8'd0;
    logic       enable;
    logic       cnt_clear_n;
    logic       running;
    logic [1:0] state;

    always #5 clk = ~clk;

    counter_enable_ctrl #(
        .PRESCALE_W(8)
    ) dut (
        .clk        (clk),
        .clear      (clear),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .clr_req    (clr_req),
        .prescale   (prescale),
        .enable     (enable),
        .cnt_clear_n(cnt_clear_n),
        .running    (running),
        .state      (state)
    );

    // Downstream counter driven by the DUT outputs.
    logic [7:0] cnt_q = 8'd0;
    always @(posedge clk) begin
        if (!cnt_clear_n) cnt_q <= 8'd0;
        else if (enable)  cnt_q <= cnt_q + 8'd1;
    end

    typedef struct packed {
        logic       en;
        logic       cn;
        logic       run;
        logic [1:0] st;
    } exp_t;

    exp_t sb_q[$];

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // Reference model state.
    int m_state = 0;
    int m_div   = 0;
    int m_cnt   = 0;
    bit m_en    = 1'b0;
    bit m_cn    = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply current inputs for one clock: predict, queue, clock, pop, compare.
    task automatic cycle();
        exp_t e;
        exp_t o;
        if (!m_cn)     m_cnt = 0;
        else if (m_en) m_cnt = (m_cnt + 1) % 256;

        if (clear) begin
            m_state = 0; m_div = 0; m_en = 1'b0; m_cn = 1'b0;
        end else begin
            m_cn = !clr_req;
            m_en = 1'b0;
            if (clr_req) begin
                m_div = 0;
                if (m_state == 2) m_state = 0;
            end else if (m_state == 0) begin
                if (stop) m_state = 0;
                else if (start) begin m_state = 1; m_div = 0; end
                else if (step) begin m_state = 2; m_en = 1'b1; end
            end else if (m_state == 1) begin
                if (stop) m_state = 0;
                else if (m_div >= int'(prescale)) begin m_en = 1'b1; m_div = 0; end
                else m_div = m_div + 1;
            end else begin
                m_state = 0;
            end
        end
        e.en  = m_en;
        e.cn  = m_cn;
        e.run = (m_state == 1);
        e.st  = 2'(m_state);
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        o = sb_q.pop_front();
        check_eq("enable",      32'(enable),      32'(o.en));
        check_eq("cnt_clear_n", 32'(cnt_clear_n), 32'(o.cn));
        check_eq("running",     32'(running),     32'(o.run));
        check_eq("state",       32'(state),       32'(o.st));
        check_eq("counter",     32'(cnt_q),       32'(m_cnt));
    endtask

    task automatic drive(input logic s_start, input logic s_stop, input logic s_step,
                         input logic s_clr, input int n);
        start   = s_start;
        stop    = s_stop;
        step    = s_step;
        clr_req = s_clr;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        // Reset held 3 cycles with start high.
        clear = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3);
        check_eq("rst_clear_n", 32'(cnt_clear_n), 32'd0);
        check_eq("rst_state",   32'(state),       32'd0);
        clear = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1);
        check_eq("rel_clear_n", 32'(cnt_clear_n), 32'd1);

        // Prescaled run, period 4.
        prescale = 8'd3;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 41);
        check_eq("ps3_count",   32'(cnt_q),   32'd10);
        check_eq("ps3_running", 32'(running), 32'd1);

        // Full rate, then stop.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1);
        check_eq("clr_count", 32'(cnt_q), 32'd0);
        prescale = 8'd0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 20);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
        check_eq("full_count",  32'(cnt_q),  32'd20);
        check_eq("stop_enable", 32'(enable), 32'd0);
        check_eq("stop_state",  32'(state),  32'd0);

        // Three spaced single steps.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 4);
        end
        check_eq("step_count", 32'(cnt_q), 32'd3);

        // Step and start ignored while running.
        prescale = 8'd10;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 15);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1);

        // Counter clear mid-run.
        prescale = 8'd1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1);
        check_eq("clrreq_clear_n", 32'(cnt_clear_n), 32'd0);
        check_eq("clrreq_running", 32'(running),     32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1);

        // start+stop together, held start released by stop.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2);
        check_eq("startstop_state", 32'(state), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2);
        check_eq("held_start_state", 32'(state), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1);

        // Lowering prescale below div.
        prescale = 8'd200;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 50);
        prescale = 8'd5;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1);
        check_eq("lower_ps_enable", 32'(enable), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 13);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1);

        // Held step, clear against step, clr_req against step.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 6);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1);
        clear = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1);
        check_eq("clr_step_enable", 32'(enable), 32'd0);
        check_eq("clr_step_state",  32'(state),  32'd0);
        clear = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1);
        clear = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1);
        check_eq("in_step_clear", 32'(state), 32'd0);
        clear = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1);
        check_eq("clrreq_step_enable", 32'(enable), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2);

        // Clear mid-run with start held.
        prescale = 8'd2;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4);
        clear = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1);
        check_eq("midrun_clear_state", 32'(state), 32'd0);
        clear = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
